irq_cond: RTL
=============

# irq_cond

Interrupt source conditioner that sits directly upstream of the interrupt controller and drives its `ints` input vector. Each raw, asynchronous peripheral interrupt line is synchronized, polarity-corrected, and delivered as a level signal. Each line is selected as either level-passthrough or edge-latched, with software acknowledge. Configuration is through a small APB slave sharing the peripheral bus.

## Interface
- `INT_NUM`, default 32: number of interrupt sources, legal range 1..32.
- `clk` input, 1 bit: single clock domain for all logic.
- `rstn` input, 1 bit: asynchronous, active-low reset.
- `psel` input, 1 bit: APB select.
- `penable` input, 1 bit: APB enable.
- `paddr` input, 32 bits: APB address; only `[11:0]` decoded.
- `pwrite` input, 1 bit: APB write.
- `pstrb` input, 4 bits: APB byte strobes.
- `pwdata` input, 32 bits: APB write data.
- `prdata` output, 32 bits: read data; 0 whenever `psel`=0, so it can be OR-combined on the bus.
- `pslverr` output, 1 bit: error for out-of-range offset.
- `pready` output, 1 bit: always 1, no wait states.
- `irq_src` input, `INT_NUM` bits: raw asynchronous peripheral interrupt lines.
- `ints` output, `INT_NUM` bits: conditioned interrupts to the interrupt controller.

## Operation
- Per-source pipeline:
  - `irq_src` → `s1` → `s2`: 2-flop synchronizer.
  - `lvl_d = s2 ^ POL`.
  - `lvl_q` is a register loaded with `lvl_d`.
- Edge detect: `rise = lvl_d & ~lvl_q`.
- `PEND[i]` is set on `rise[i]` when `MODE[i]`=1.
  - Cleared by APB write-1-to-clear.
  - Set wins over a same-cycle clear.
  - Forced to 0 while `MODE[i]`=0.
- Output: `ints[i] = MODE[i] ? PEND[i] : lvl_q[i]`. Driven directly from flops, no combinational path from `irq_src`.
- Registers: 32-bit, word offsets, decoded on `paddr[3:2]`, bits ≥ `INT_NUM` read 0.
  - `0x00 MODE` RW, reset 0: 1 = edge-latched, 0 = level.
  - `0x04 POL` RW, reset 0: 1 = source is active-low.
  - `0x08 PEND` R/W1C, reset 0.
  - `0x0C RAW` RO: current `lvl_q`.
- APB access rules:
  - Writes take effect on the cycle `psel & penable & pwrite`.
  - Byte lanes are gated by `pstrb`.
  - Reads are combinational from register state.
- Error: `pslverr`=1 during the access phase when `paddr[11:4]`≠0. Writes to such offsets have no effect; reads return 0.
- Writing `POL` may create a `rise` on the next cycle. Software clears `PEND` after changing `POL`. This is required behaviour, not a bug.
- Writing `MODE[i]` 1→0 clears `PEND[i]` on the same edge. Writing 0→1 does not set `PEND` from an already-high level; only a subsequent rise sets it.

## Timing
- Reset (asynchronous, `rstn`=0):
  - `s1`, `s2`, `lvl_q`, `MODE`, `POL`, `PEND` all 0.
  - Outputs: `ints`=0, `prdata`=0, `pslverr`=0, `pready`=1.
- Level-mode latency: an `irq_src` change sampled at edge N appears on `ints` after edge N+2, i.e. 3 clocks from a setup-meeting change.
- Edge-mode latency: `PEND` sets on the same edge `lvl_q` rises, so also 3 clocks.
- Pulses shorter than one clock may be missed; edge sources must hold ≥2 clocks.
- W1C of `PEND`: `ints` falls the cycle after the access phase. If a rise is coincident, `PEND` stays 1.
- Reset asserted mid-operation clears all state immediately. After deassert, an already-active source reappears on `ints` after 3 clocks in level mode; in edge mode it latches as a fresh rise.

## Configuration
- `IRQ_GLITCH_FILTER_EN`, defined:
  - A per-source 2-bit counter sits between `lvl_d` and `lvl_q`.
  - `lvl_q` updates only after `lvl_d` ≠ `lvl_q` for 3 consecutive cycles.
  - The counter resets when `lvl_d` = `lvl_q`.
  - Latency becomes 5 clocks.
  - Pulses of ≤2 clocks after the synchronizer are rejected.
- Not defined: no counter; `lvl_q <= lvl_d` every cycle, timing as above.

## Test plan
- Level passthrough: reset, `MODE`=0, `POL`=0; raise `irq_src[3]` → `ints[3]`=1 after 3 clocks (5 with filter); drop it → `ints[3]`=0 after the same latency; `RAW` reads 0x8 while high.
- Edge latch: `MODE`=0x1; pulse `irq_src[0]` high for 4 clocks → `ints[0]` stays 1 after the pulse; write `PEND`=0x1 → `ints[0]`=0 the next cycle; `PEND` reads 0.
- Simultaneous set/clear: `MODE`=0x1 with `PEND[0]`=1; W1C 0x1 on the exact edge a new rise is detected → `PEND[0]`=1, `ints[0]`=1.
- Polarity: `POL`=0x4, `irq_src[2]`=1 → `ints[2]`=0; drive `irq_src[2]`=0 → `ints[2]`=1 after 3 clocks.
- APB error and strobes:
  - Read offset 0x10 → `pslverr`=1, `prdata`=0.
  - Write `MODE` 0xFFFFFFFF with `pstrb`=0x1 → `MODE` reads 0x000000FF.
  - `prdata`=0 while `psel`=0.
- Filter and reset (`IRQ_GLITCH_FILTER_EN` defined): a 2-clock glitch on `irq_src[1]` → `ints[1]` never rises. Assert `rstn` mid-pulse → `ints`=0 immediately and `MODE`/`POL`/`PEND`=0.

Source files
------------

// File: rtl/irq_cond.sv
// Interrupt source conditioner: synchronizes, polarity-corrects and level/edge-conditions
// raw interrupt lines, configured over APB. Optional glitch filter: IRQ_GLITCH_FILTER_EN.
module irq_cond #(
  parameter int INT_NUM = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               psel,
  input  logic               penable,
  input  logic [31:0]        paddr,
  input  logic               pwrite,
  input  logic [3:0]         pstrb,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pslverr,
  output logic               pready,
  input  logic [INT_NUM-1:0] irq_src,
  output logic [INT_NUM-1:0] ints
);

  logic [INT_NUM-1:0] r_s1, r_s2, r_lvlQ, r_mode, r_pol, r_pend;
  logic [INT_NUM-1:0] w_lvlD, w_lvlNext, w_rise;
  logic [INT_NUM-1:0] w_modeNext, w_polNext, w_pendClr, w_pendNext;
  logic [31:0]        w_wmask, w_wbits, w_rdData;
  logic               w_access, w_err, w_wrEn, w_wrMode, w_wrPol, w_wrPend;
  logic               w_unusedAddr;

  assign w_unusedAddr = ^{paddr[31:12], paddr[1:0]};

  assign w_access = psel & penable;
  assign w_err    = |paddr[11:4];
  assign w_wrEn   = w_access & pwrite & ~w_err;
  assign w_wrMode = w_wrEn & (paddr[3:2] == 2'd0);
  assign w_wrPol  = w_wrEn & (paddr[3:2] == 2'd1);
  assign w_wrPend = w_wrEn & (paddr[3:2] == 2'd2);

  assign w_wmask = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}};
  assign w_wbits = pwdata & w_wmask;

  always_comb begin
    w_modeNext = r_mode;
    w_polNext  = r_pol;
    w_pendClr  = '0;
    if (w_wrMode) w_modeNext = (r_mode & ~w_wmask[INT_NUM-1:0]) | w_wbits[INT_NUM-1:0];
    if (w_wrPol)  w_polNext  = (r_pol & ~w_wmask[INT_NUM-1:0]) | w_wbits[INT_NUM-1:0];
    if (w_wrPend) w_pendClr  = w_wbits[INT_NUM-1:0];
  end

  assign w_lvlD = r_s2 ^ r_pol;

`ifdef IRQ_GLITCH_FILTER_EN
  // lvl_q follows lvl_d only after three consecutive cycles of disagreement
  logic [INT_NUM-1:0][1:0] r_cnt;
  logic [INT_NUM-1:0]      w_flip;

  always_comb begin
    w_flip = '0;
    for (int i = 0; i < INT_NUM; i++) begin
      w_flip[i] = (w_lvlD[i] != r_lvlQ[i]) && (r_cnt[i] == 2'd2);
    end
  end

  assign w_lvlNext = r_lvlQ ^ w_flip;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else begin
      for (int i = 0; i < INT_NUM; i++) begin
        if ((w_lvlD[i] == r_lvlQ[i]) || w_flip[i]) r_cnt[i] <= 2'd0;
        else                                      r_cnt[i] <= r_cnt[i] + 2'd1;
      end
    end
  end
`else
  assign w_lvlNext = w_lvlD;
`endif

  // Set beats a same-cycle W1C; clearing MODE drops PEND on the same edge
  assign w_rise     = w_lvlNext & ~r_lvlQ;
  assign w_pendNext = w_modeNext & ((w_rise & r_mode) | (r_pend & ~w_pendClr));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_lvlQ <= '0;
      r_mode <= '0;
      r_pol  <= '0;
      r_pend <= '0;
    end else begin
      r_s1   <= irq_src;
      r_s2   <= r_s1;
      r_lvlQ <= w_lvlNext;
      r_mode <= w_modeNext;
      r_pol  <= w_polNext;
      r_pend <= w_pendNext;
    end
  end

  always_comb begin
    w_rdData = '0;
    case (paddr[3:2])
      2'd0:    w_rdData[INT_NUM-1:0] = r_mode;
      2'd1:    w_rdData[INT_NUM-1:0] = r_pol;
      2'd2:    w_rdData[INT_NUM-1:0] = r_pend;
      default: w_rdData[INT_NUM-1:0] = r_lvlQ;
    endcase
  end

  assign prdata  = (psel && !w_err) ? w_rdData : 32'd0;
  assign pslverr = w_access & w_err;
  assign pready  = 1'b1;

  assign ints = (r_mode & r_pend) | (~r_mode & r_lvlQ);

endmodule
